siso_demux4: RTL and testbench

SISO_DEMUX4 -- requirements
Module: siso_demux4

---
 rtl/siso_pkg.sv | 12 +
 rtl/nibble_fifo2.sv | 57 +++++
 rtl/siso_demux4.sv | 104 ++++++++++
 tb/tb_siso_demux4.sv | 230 +++++++++++++++++++++++
 4 files changed

// File: rtl/siso_pkg.sv
// Shared constants and types for the serial-to-4-lane demultiplexer.
package siso_pkg;
  localparam int LANES         = 4;
  localparam int FIFO_DEPTH    = 2;
  localparam int CNT_W         = $clog2(LANES);
  localparam int LVL_W         = $clog2(FIFO_DEPTH + 1);
  localparam int CONSUME_PHASE = 7;

  typedef logic [LANES-1:0] nibble_t;

  localparam nibble_t IDLE_NIBBLE = 4'b0000;
endpackage

// File: rtl/nibble_fifo2.sv
// Two-entry nibble FIFO. A pop is evaluated before a push on the same edge,
// so a full FIFO can accept while draining, and an empty one never bypasses.
module nibble_fifo2
  import siso_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_push,
  input  nibble_t          i_data,
  input  logic             i_pop,
  output nibble_t          o_rd_data,
  output logic             o_pop_ok,
  output logic             o_drop,
  output logic [LVL_W-1:0] o_lvl
);

  nibble_t          r_mem [FIFO_DEPTH];
  logic             r_wr_ptr;
  logic             r_rd_ptr;
  logic [LVL_W-1:0] r_lvl;

  logic w_full;
  logic w_pop_ok;
  logic w_push_ok;

  assign w_full    = (r_lvl == LVL_W'(FIFO_DEPTH));
  assign w_pop_ok  = i_pop && (r_lvl != '0);
  assign w_push_ok = i_push && (!w_full || w_pop_ok);

  assign o_rd_data = r_mem[r_rd_ptr];
  assign o_pop_ok  = w_pop_ok;
  assign o_drop    = i_push && !w_push_ok;
  assign o_lvl     = r_lvl;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < FIFO_DEPTH; i++) r_mem[i] <= IDLE_NIBBLE;
      r_wr_ptr <= 1'b0;
      r_rd_ptr <= 1'b0;
      r_lvl    <= '0;
    end else begin
      // At full with a pop, wr_ptr equals rd_ptr: the slot is read out and
      // overwritten on the same edge.
      if (w_push_ok) begin
        r_mem[r_wr_ptr] <= i_data;
        r_wr_ptr        <= ~r_wr_ptr;
      end
      if (w_pop_ok) r_rd_ptr <= ~r_rd_ptr;
      case ({w_push_ok, w_pop_ok})
        2'b10:   r_lvl <= r_lvl + 1'b1;
        2'b01:   r_lvl <= r_lvl - 1'b1;
        default: r_lvl <= r_lvl;
      endcase
    end
  end

endmodule

// File: rtl/siso_demux4.sv
// Serial bit assembler feeding a 2-entry FIFO that drains one nibble onto
// LANE4 per consume strobe (PHASE[7]), with sticky overrun/underrun flags.
module siso_demux4
  import siso_pkg::*;
(
  input  logic             CLK,
  input  logic             RESET,
  input  logic             D_IN,
  input  logic             D_VALID,
  input  logic [7:0]       PHASE,
  input  logic             ALIGN,
  input  logic             CLR_FLAGS,
  output logic [LANES-1:0] LANE4,
  output logic             LANE_LOAD,
  output logic [1:0]       FIFO_LVL,
  output logic             OVERRUN,
  output logic             UNDERRUN
);

  logic [CNT_W-1:0] r_bit_cnt;
  nibble_t          r_asm;
  nibble_t          r_lane4;
  logic             r_lane_load;
  logic             r_overrun;
  logic             r_underrun;

  logic             w_consume;
  logic             w_accept;
  logic             w_push;
  nibble_t          w_nibble;
  nibble_t          w_rd_data;
  logic             w_pop_ok;
  logic             w_drop;
  logic [LVL_W-1:0] w_lvl;
  logic             w_unused_phase;

  // Only the consume phase is decoded; the other strobes are ignored.
  assign w_consume      = PHASE[CONSUME_PHASE];
  assign w_unused_phase = ^PHASE;

  assign w_accept = D_VALID && !ALIGN;
  assign w_push   = w_accept && (r_bit_cnt == CNT_W'(LANES - 1));

  always_comb begin
    w_nibble            = r_asm;
    w_nibble[r_bit_cnt] = D_IN;
  end

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      r_bit_cnt <= '0;
      r_asm     <= IDLE_NIBBLE;
    end else if (ALIGN) begin
      r_bit_cnt <= '0;
      r_asm     <= IDLE_NIBBLE;
    end else if (w_push) begin
      r_bit_cnt <= '0;
      r_asm     <= IDLE_NIBBLE;
    end else if (w_accept) begin
      r_bit_cnt <= r_bit_cnt + 1'b1;
      r_asm     <= w_nibble;
    end
  end

  nibble_fifo2 u_fifo (
    .clk       (CLK),
    .rst_n     (RESET),
    .i_push    (w_push),
    .i_data    (w_nibble),
    .i_pop     (w_consume),
    .o_rd_data (w_rd_data),
    .o_pop_ok  (w_pop_ok),
    .o_drop    (w_drop),
    .o_lvl     (w_lvl)
  );

  // An empty consume presents the idle nibble rather than holding stale data.
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      r_lane4     <= IDLE_NIBBLE;
      r_lane_load <= 1'b0;
    end else begin
      r_lane_load <= w_consume && w_pop_ok;
      if (w_consume) r_lane4 <= w_pop_ok ? w_rd_data : IDLE_NIBBLE;
    end
  end

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      r_overrun  <= 1'b0;
      r_underrun <= 1'b0;
    end else begin
      r_overrun  <= w_drop || (r_overrun && !CLR_FLAGS);
      r_underrun <= (w_consume && !w_pop_ok) || (r_underrun && !CLR_FLAGS);
    end
  end

  assign LANE4     = r_lane4;
  assign LANE_LOAD = r_lane_load;
  assign FIFO_LVL  = w_lvl;
  assign OVERRUN   = r_overrun;
  assign UNDERRUN  = r_underrun;

endmodule

// File: tb/tb_siso_demux4.sv
// Directed bench for siso_demux4: one task per scenario, inline checks.
module tb_siso_demux4;

  logic       CLK;
  logic       RESET;
  logic       D_IN;
  logic       D_VALID;
  logic [7:0] PHASE;
  logic       ALIGN;
  logic       CLR_FLAGS;
  logic [3:0] LANE4;
  logic       LANE_LOAD;
  logic [1:0] FIFO_LVL;
  logic       OVERRUN;
  logic       UNDERRUN;

  int n_checks = 0;
  int n_pass   = 0;

  siso_demux4 dut (
    .CLK       (CLK),
    .RESET     (RESET),
    .D_IN      (D_IN),
    .D_VALID   (D_VALID),
    .PHASE     (PHASE),
    .ALIGN     (ALIGN),
    .CLR_FLAGS (CLR_FLAGS),
    .LANE4     (LANE4),
    .LANE_LOAD (LANE_LOAD),
    .FIFO_LVL  (FIFO_LVL),
    .OVERRUN   (OVERRUN),
    .UNDERRUN  (UNDERRUN)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic cyc();
    @(posedge CLK);
    #1;
  endtask

  // Sends a nibble lane 0 first, leaving D_VALID low afterwards.
  task automatic send_nibble(input logic [3:0] n);
    for (int i = 0; i < 4; i++) begin
      D_VALID = 1'b1;
      D_IN    = n[i];
      cyc();
    end
    D_VALID = 1'b0;
    D_IN    = 1'b0;
  endtask

  task automatic consume();
    PHASE = 8'h80;
    cyc();
    PHASE = 8'h00;
  endtask

  task automatic clear_flags();
    CLR_FLAGS = 1'b1;
    cyc();
    CLR_FLAGS = 1'b0;
  endtask

  task automatic test_reset();
    RESET = 1'b1; D_IN = 1'b0; D_VALID = 1'b0; PHASE = 8'h00;
    ALIGN = 1'b0; CLR_FLAGS = 1'b0;
    #2 RESET = 1'b0;
    #1;
    n_checks++; if (LANE4 !== 4'h0) $display("FAIL rst_lane4 got %h exp %h", LANE4, 4'h0); else n_pass++;
    n_checks++; if (LANE_LOAD !== 1'b0) $display("FAIL rst_load got %b exp 0", LANE_LOAD); else n_pass++;
    n_checks++; if (FIFO_LVL !== 2'd0) $display("FAIL rst_lvl got %0d exp 0", FIFO_LVL); else n_pass++;
    n_checks++; if (OVERRUN !== 1'b0) $display("FAIL rst_ovr got %b exp 0", OVERRUN); else n_pass++;
    n_checks++; if (UNDERRUN !== 1'b0) $display("FAIL rst_udr got %b exp 0", UNDERRUN); else n_pass++;
    cyc();
    RESET = 1'b1;
    cyc();
  endtask

  task automatic test_basic();
    int loads;
    send_nibble(4'b1101);
    n_checks++; if (FIFO_LVL !== 2'd1) $display("FAIL basic_lvl1 got %0d exp 1", FIFO_LVL); else n_pass++;
    n_checks++; if (LANE_LOAD !== 1'b0) $display("FAIL basic_noload got %b exp 0", LANE_LOAD); else n_pass++;
    repeat (3) cyc();
    loads = 0;
    consume();
    if (LANE_LOAD === 1'b1) loads++;
    n_checks++; if (LANE4 !== 4'b1101) $display("FAIL basic_lane4 got %b exp 1101", LANE4); else n_pass++;
    n_checks++; if (FIFO_LVL !== 2'd0) $display("FAIL basic_lvl0 got %0d exp 0", FIFO_LVL); else n_pass++;
    for (int i = 0; i < 3; i++) begin
      cyc();
      if (LANE_LOAD === 1'b1) loads++;
    end
    n_checks++; if (loads !== 1) $display("FAIL basic_pulses got %0d exp 1", loads); else n_pass++;
    n_checks++; if (LANE4 !== 4'b1101) $display("FAIL basic_hold got %b exp 1101", LANE4); else n_pass++;
    n_checks++; if ({OVERRUN, UNDERRUN} !== 2'b00) $display("FAIL basic_flags got %b exp 00", {OVERRUN, UNDERRUN}); else n_pass++;
  endtask

  task automatic test_overrun();
    send_nibble(4'hA);
    send_nibble(4'h5);
    n_checks++; if (OVERRUN !== 1'b0) $display("FAIL ovr_early got %b exp 0", OVERRUN); else n_pass++;
    send_nibble(4'hF);
    n_checks++; if (FIFO_LVL !== 2'd2) $display("FAIL ovr_lvl got %0d exp 2", FIFO_LVL); else n_pass++;
    n_checks++; if (OVERRUN !== 1'b1) $display("FAIL ovr_flag got %b exp 1", OVERRUN); else n_pass++;
    consume();
    n_checks++; if (LANE4 !== 4'hA) $display("FAIL ovr_first got %h exp a", LANE4); else n_pass++;
    n_checks++; if (LANE_LOAD !== 1'b1) $display("FAIL ovr_load1 got %b exp 1", LANE_LOAD); else n_pass++;
    consume();
    n_checks++; if (LANE4 !== 4'h5) $display("FAIL ovr_second got %h exp 5", LANE4); else n_pass++;
    n_checks++; if (FIFO_LVL !== 2'd0) $display("FAIL ovr_drained got %0d exp 0", FIFO_LVL); else n_pass++;
    clear_flags();
    n_checks++; if (OVERRUN !== 1'b0) $display("FAIL ovr_clear got %b exp 0", OVERRUN); else n_pass++;
  endtask

  task automatic test_underrun();
    consume();
    n_checks++; if (LANE4 !== 4'h0) $display("FAIL udr_lane4 got %h exp 0", LANE4); else n_pass++;
    n_checks++; if (LANE_LOAD !== 1'b0) $display("FAIL udr_load got %b exp 0", LANE_LOAD); else n_pass++;
    n_checks++; if (UNDERRUN !== 1'b1) $display("FAIL udr_flag got %b exp 1", UNDERRUN); else n_pass++;
    clear_flags();
    n_checks++; if (UNDERRUN !== 1'b0) $display("FAIL udr_clear got %b exp 0", UNDERRUN); else n_pass++;
    CLR_FLAGS = 1'b1;
    consume();
    CLR_FLAGS = 1'b0;
    n_checks++; if (UNDERRUN !== 1'b1) $display("FAIL udr_set_wins got %b exp 1", UNDERRUN); else n_pass++;
    clear_flags();
  endtask

  task automatic test_align();
    logic [3:0] exp_lvl;
    D_VALID = 1'b1; D_IN = 1'b1; cyc();
    D_IN = 1'b0; cyc();
    ALIGN = 1'b1; D_IN = 1'b1; cyc();
    ALIGN = 1'b0;
    n_checks++; if (FIFO_LVL !== 2'd0) $display("FAIL align_nopush got %0d exp 0", FIFO_LVL); else n_pass++;
    exp_lvl = 4'b1000;
    for (int i = 0; i < 4; i++) begin
      D_VALID = 1'b1; D_IN = 1'b1; cyc();
      n_checks++; if (FIFO_LVL !== {1'b0, exp_lvl[i]}) $display("FAIL align_lvl%0d got %0d exp %0d", i, FIFO_LVL, exp_lvl[i]); else n_pass++;
    end
    D_VALID = 1'b0;
    consume();
    n_checks++; if (LANE4 !== 4'hF) $display("FAIL align_nib got %h exp f", LANE4); else n_pass++;
    for (int i = 0; i < 3; i++) begin
      D_VALID = 1'b1; D_IN = 1'b1; cyc();
    end
    ALIGN = 1'b1; cyc();
    ALIGN = 1'b0; D_VALID = 1'b0;
    n_checks++; if (FIFO_LVL !== 2'd0) $display("FAIL align_prio got %0d exp 0", FIFO_LVL); else n_pass++;
    send_nibble(4'hC);
    n_checks++; if (FIFO_LVL !== 2'd1) $display("FAIL align_after got %0d exp 1", FIFO_LVL); else n_pass++;
    consume();
    n_checks++; if (LANE4 !== 4'hC) $display("FAIL align_after_nib got %h exp c", LANE4); else n_pass++;
  endtask

  task automatic test_simultaneous();
    logic [3:0] n;
    send_nibble(4'h3);
    send_nibble(4'h6);
    n = 4'h9;
    for (int i = 0; i < 3; i++) begin
      D_VALID = 1'b1; D_IN = n[i]; cyc();
    end
    D_IN = n[3]; PHASE = 8'h80; cyc();
    D_VALID = 1'b0; PHASE = 8'h00;
    n_checks++; if (FIFO_LVL !== 2'd2) $display("FAIL sim_full_lvl got %0d exp 2", FIFO_LVL); else n_pass++;
    n_checks++; if (OVERRUN !== 1'b0) $display("FAIL sim_full_ovr got %b exp 0", OVERRUN); else n_pass++;
    n_checks++; if (LANE4 !== 4'h3) $display("FAIL sim_full_oldest got %h exp 3", LANE4); else n_pass++;
    consume();
    n_checks++; if (LANE4 !== 4'h6) $display("FAIL sim_full_2nd got %h exp 6", LANE4); else n_pass++;
    consume();
    n_checks++; if (LANE4 !== 4'h9) $display("FAIL sim_full_3rd got %h exp 9", LANE4); else n_pass++;
    n = 4'h2;
    for (int i = 0; i < 3; i++) begin
      D_VALID = 1'b1; D_IN = n[i]; cyc();
    end
    D_IN = n[3]; PHASE = 8'h80; cyc();
    D_VALID = 1'b0; PHASE = 8'h00;
    n_checks++; if (LANE4 !== 4'h0) $display("FAIL sim_empty_lane4 got %h exp 0", LANE4); else n_pass++;
    n_checks++; if (LANE_LOAD !== 1'b0) $display("FAIL sim_empty_load got %b exp 0", LANE_LOAD); else n_pass++;
    n_checks++; if (UNDERRUN !== 1'b1) $display("FAIL sim_empty_udr got %b exp 1", UNDERRUN); else n_pass++;
    n_checks++; if (FIFO_LVL !== 2'd1) $display("FAIL sim_empty_lvl got %0d exp 1", FIFO_LVL); else n_pass++;
    consume();
    n_checks++; if (LANE4 !== 4'h2) $display("FAIL sim_empty_nib got %h exp 2", LANE4); else n_pass++;
    clear_flags();
  endtask

  task automatic test_reset_mid();
    send_nibble(4'hE);
    D_VALID = 1'b1; D_IN = 1'b1; cyc();
    D_IN = 1'b1; cyc();
    D_VALID = 1'b0;
    n_checks++; if (FIFO_LVL !== 2'd1) $display("FAIL rmid_pre_lvl got %0d exp 1", FIFO_LVL); else n_pass++;
    #2 RESET = 1'b0;
    #1;
    n_checks++; if (LANE4 !== 4'h0) $display("FAIL rmid_lane4 got %h exp 0", LANE4); else n_pass++;
    n_checks++; if (FIFO_LVL !== 2'd0) $display("FAIL rmid_lvl got %0d exp 0", FIFO_LVL); else n_pass++;
    n_checks++; if ({LANE_LOAD, OVERRUN, UNDERRUN} !== 3'b000) $display("FAIL rmid_ctl got %b exp 000", {LANE_LOAD, OVERRUN, UNDERRUN}); else n_pass++;
    cyc();
    RESET = 1'b1;
    cyc();
    n_checks++; if ({FIFO_LVL, LANE_LOAD} !== 3'b000) $display("FAIL rmid_release got %b exp 000", {FIFO_LVL, LANE_LOAD}); else n_pass++;
    send_nibble(4'h6);
    n_checks++; if (FIFO_LVL !== 2'd1) $display("FAIL rmid_fresh_lvl got %0d exp 1", FIFO_LVL); else n_pass++;
    consume();
    n_checks++; if (LANE4 !== 4'h6) $display("FAIL rmid_fresh_nib got %h exp 6", LANE4); else n_pass++;
  endtask

  initial begin
    test_reset();
    test_basic();
    test_overrun();
    test_underrun();
    test_align();
    test_simultaneous();
    test_reset_mid();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
